// File: rtl/mips_pkg.sv
// Shared MIPS constants for the EX-stage mul/div sequencer, alu_control and the decoder.
// Holds the 2-bit mul/div op encodings, the sequencer state codes and the R-type function codes.
package mips_pkg;

  // Mul/div op as decoded from the function field
  localparam logic [1:0] MULDIV_OP_MULT  = 2'b00;
  localparam logic [1:0] MULDIV_OP_MULTU = 2'b01;
  localparam logic [1:0] MULDIV_OP_DIV   = 2'b10;
  localparam logic [1:0] MULDIV_OP_DIVU  = 2'b11;

  // Sequencer states: IDLE -> CALC -> FIX -> IDLE
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  // R-type function codes
  localparam logic [5:0] FUNC_MFHI  = 6'h10;
  localparam logic [5:0] FUNC_MFLO  = 6'h12;
  localparam logic [5:0] FUNC_MULT  = 6'h18;
  localparam logic [5:0] FUNC_MULTU = 6'h19;
  localparam logic [5:0] FUNC_DIV   = 6'h1A;
  localparam logic [5:0] FUNC_DIVU  = 6'h1B;

  // Bit 1 of the op selects divide, bit 0 selects unsigned
  function automatic logic muldiv_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic muldiv_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the mul/div datapath, purely combinational.
//  is_div_i   : 1 = restoring divide step, 0 = shift-add multiply step
//  acc_i/o    : accumulator (product high half / partial remainder)
//  opnd_i/o   : operand register (multiplier shifting into product low half / dividend shifting into quotient)
//  addend_i   : multiplicand / divisor magnitude, constant over the operation
module muldiv_step #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              is_div_i,
  input  logic [DATA_W-1:0] acc_i,
  input  logic [DATA_W-1:0] opnd_i,
  input  logic [DATA_W-1:0] addend_i,
  output logic [DATA_W-1:0] acc_o,
  output logic [DATA_W-1:0] opnd_o
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] mul_acc;
  logic [DATA_W:0] rem_sh;
  logic [DATA_W:0] diff;

  always_comb begin
    sum     = {1'b0, acc_i} + {1'b0, addend_i};
    mul_acc = opnd_i[0] ? sum : {1'b0, acc_i};
    rem_sh  = {acc_i, opnd_i[DATA_W-1]};
    diff    = rem_sh - {1'b0, addend_i};
    acc_o   = acc_i;
    opnd_o  = opnd_i;
    if (is_div_i) begin
      // Top bit of diff set means the trial subtract borrowed: keep the shifted remainder
      if (!diff[DATA_W]) begin
        acc_o  = diff[DATA_W-1:0];
        opnd_o = {opnd_i[DATA_W-2:0], 1'b1};
      end else begin
        acc_o  = rem_sh[DATA_W-1:0];
        opnd_o = {opnd_i[DATA_W-2:0], 1'b0};
      end
    end else begin
      // Shift {carry, acc, opnd} right by one; the product fills opnd from the top
      acc_o  = mul_acc[DATA_W:1];
      opnd_o = {mul_acc[0], opnd_i[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer beside the EX-stage ALU; owns HI/LO and stalls the
// front of the pipeline while busy.
//  clk, reset          : clock, asynchronous active-high reset
//  i_start, i_op       : mul/div in EX this cycle, op encoding (MULDIV_OP_*)
//  i_operand_a/b       : rs / rt values
//  i_hilo_read         : MFHI/MFLO in EX this cycle
//  i_flush             : squash the in-flight operation
//  o_busy, o_stall     : sequencer not idle, freeze PC/IF/ID/EX (combinational)
//  o_done              : one-cycle pulse when HI/LO take a new result
//  o_hi, o_lo          : HI / LO registers
module ex_muldiv_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic [1:0]        i_op,
  input  logic [DATA_W-1:0] i_operand_a,
  input  logic [DATA_W-1:0] i_operand_b,
  input  logic              i_hilo_read,
  input  logic              i_flush,
  output logic              o_busy,
  output logic              o_stall,
  output logic              o_done,
  output logic [DATA_W-1:0] o_hi,
  output logic [DATA_W-1:0] o_lo
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              is_div_q, is_div_d;
  logic              sign_a_q, sign_a_d;
  logic              sign_b_q, sign_b_d;
  logic              div0_q, div0_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] opnd_q, opnd_d;
  logic [DATA_W-1:0] addend_q, addend_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              done_q, done_d;
  logic              busy_q;

  logic [DATA_W-1:0]   step_acc, step_opnd;
  logic                op_div, op_signed, neg_res;
  logic [2*DATA_W-1:0] prod, prod_fix;
  logic [DATA_W-1:0]   quot_fix, rem_fix, a_raw;

  muldiv_step #(.DATA_W(DATA_W)) u_step (
    .is_div_i (is_div_q),
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .addend_i (addend_q),
    .acc_o    (step_acc),
    .opnd_o   (step_opnd)
  );

  // Next-state, datapath load/iterate and signed fix-up
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    div0_d   = div0_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    addend_d = addend_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    op_div    = muldiv_is_div(i_op);
    op_signed = muldiv_is_signed(i_op);

    // Sign flags are zero for unsigned ops, so the fix-up below is a no-op for them
    neg_res  = sign_a_q ^ sign_b_q;
    prod     = {acc_q, opnd_q};
    prod_fix = neg_res ? -prod : prod;
    quot_fix = neg_res ? -opnd_q : opnd_q;
    rem_fix  = sign_a_q ? -acc_q : acc_q;
    // Divide-by-zero never iterates, so opnd still holds |a|; rebuild the raw operand
    a_raw    = sign_a_q ? -opnd_q : opnd_q;

    case (state_q)
      ST_IDLE: begin
        if (i_start && !i_flush) begin
          is_div_d = op_div;
          sign_a_d = op_signed & i_operand_a[DATA_W-1];
          sign_b_d = op_signed & i_operand_b[DATA_W-1];
          acc_d    = '0;
          opnd_d   = (op_signed & i_operand_a[DATA_W-1]) ? -i_operand_a : i_operand_a;
          addend_d = (op_signed & i_operand_b[DATA_W-1]) ? -i_operand_b : i_operand_b;
          cnt_d    = '0;
          div0_d   = op_div && (i_operand_b == '0);
          state_d  = (op_div && (i_operand_b == '0)) ? ST_FIX : ST_CALC;
        end
      end
      ST_CALC: begin
        if (i_flush) begin
          state_d = ST_IDLE;
        end else begin
          acc_d  = step_acc;
          opnd_d = step_opnd;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        if (!i_flush) begin
          done_d = 1'b1;
          if (div0_q) begin
            hi_d = a_raw;
            lo_d = '1;
          end else if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end else begin
            hi_d = prod_fix[2*DATA_W-1:DATA_W];
            lo_d = prod_fix[DATA_W-1:0];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      div0_q   <= 1'b0;
      acc_q    <= '0;
      opnd_q   <= '0;
      addend_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      div0_q   <= div0_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      addend_q <= addend_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      busy_q   <= (state_d != ST_IDLE);
    end
  end

  assign o_busy  = busy_q;
  assign o_stall = busy_q & (i_start | i_hilo_read);
  assign o_done  = done_q;
  assign o_hi    = hi_q;
  assign o_lo    = lo_q;

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Directed self-checking bench for ex_muldiv_ctrl. Inputs change 1 time unit after the rising
// edge, outputs are sampled 2 time units after it. "Cycle 0" is the cycle i_start is presented.
module tb_ex_muldiv_ctrl;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_start;
  logic [1:0]  i_op;
  logic [31:0] i_operand_a;
  logic [31:0] i_operand_b;
  logic        i_hilo_read;
  logic        i_flush;
  logic        o_busy;
  logic        o_stall;
  logic        o_done;
  logic [31:0] o_hi;
  logic [31:0] o_lo;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  ex_muldiv_ctrl #(.DATA_W(32), .CNT_W(6)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_start     (i_start),
    .i_op        (i_op),
    .i_operand_a (i_operand_a),
    .i_operand_b (i_operand_b),
    .i_hilo_read (i_hilo_read),
    .i_flush     (i_flush),
    .o_busy      (o_busy),
    .o_stall     (o_stall),
    .o_done      (o_done),
    .o_hi        (o_hi),
    .o_lo        (o_lo)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    i_op        = op;
    i_operand_a = a;
    i_operand_b = b;
    i_start     = 1'b1;
  endtask

  // Drops i_start in cycle 1 and waits (bounded) for o_done; lat stays -1 on timeout
  task automatic wait_done(output int lat, output int busy_first, output int busy_last);
    lat = -1; busy_first = -1; busy_last = -1;
    for (int c = 1; c <= 100; c++) begin
      tick();
      if (c == 1) i_start = 1'b0;
      #1;
      if (o_busy) begin
        if (busy_first < 0) busy_first = c;
        busy_last = c;
      end
      if (o_done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; i_start = 1'b1; i_op = OP_MULT; i_operand_a = 32'd3; i_operand_b = 32'd4;
    i_hilo_read = 1'b1; i_flush = 1'b0;
    #3;
    n_total++; if (o_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", o_busy); else n_pass++;
    n_total++; if (o_stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", o_stall); else n_pass++;
    n_total++; if (o_done !== 1'b0) $display("FAIL reset_done: got %b want 0", o_done); else n_pass++;
    n_total++; if (o_hi !== 32'h0) $display("FAIL reset_hi: got %h want 0", o_hi); else n_pass++;
    n_total++; if (o_lo !== 32'h0) $display("FAIL reset_lo: got %h want 0", o_lo); else n_pass++;
    tick(); tick();
    i_start = 1'b0; i_hilo_read = 1'b0;
    reset = 1'b0;
    tick(); #1;
  endtask

  task automatic test_multu_max();
    int lat, bf, bl;
    launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(lat, bf, bl);
    n_total++; if (lat != 34) $display("FAIL multu_latency: got %0d want 34", lat); else n_pass++;
    n_total++; if (o_hi !== 32'hFFFF_FFFE) $display("FAIL multu_hi: got %h want fffffffe", o_hi); else n_pass++;
    n_total++; if (o_lo !== 32'h0000_0001) $display("FAIL multu_lo: got %h want 00000001", o_lo); else n_pass++;
    n_total++; if (bf != 1) $display("FAIL multu_busy_first: got %0d want 1", bf); else n_pass++;
    n_total++; if (bl != 33) $display("FAIL multu_busy_last: got %0d want 33", bl); else n_pass++;
    tick(); #1;
    n_total++; if (o_done !== 1'b0) $display("FAIL done_pulse_width: got %b want 0", o_done); else n_pass++;
  endtask

  task automatic test_signed();
    int lat, bf, bl;
    launch(OP_MULT, 32'hFFFF_FFF9, 32'd6);
    wait_done(lat, bf, bl);
    n_total++; if (lat != 34) $display("FAIL mult_latency: got %0d want 34", lat); else n_pass++;
    n_total++; if (o_hi !== 32'hFFFF_FFFF) $display("FAIL mult_neg_hi: got %h want ffffffff", o_hi); else n_pass++;
    n_total++; if (o_lo !== 32'hFFFF_FFD6) $display("FAIL mult_neg_lo: got %h want ffffffd6", o_lo); else n_pass++;
    launch(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(lat, bf, bl);
    n_total++; if (lat != 34) $display("FAIL div_latency: got %0d want 34", lat); else n_pass++;
    n_total++; if (o_lo !== 32'hFFFF_FFFD) $display("FAIL div_neg_quot: got %h want fffffffd", o_lo); else n_pass++;
    n_total++; if (o_hi !== 32'hFFFF_FFFF) $display("FAIL div_neg_rem: got %h want ffffffff", o_hi); else n_pass++;
  endtask

  task automatic test_div_edges();
    int lat, bf, bl;
    launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(lat, bf, bl);
    n_total++; if (o_lo !== 32'h8000_0000) $display("FAIL div_min_quot: got %h want 80000000", o_lo); else n_pass++;
    n_total++; if (o_hi !== 32'h0) $display("FAIL div_min_rem: got %h want 0", o_hi); else n_pass++;
    launch(OP_DIVU, 32'd5, 32'd0);
    wait_done(lat, bf, bl);
    n_total++; if (lat != 2) $display("FAIL div0_latency: got %0d want 2", lat); else n_pass++;
    n_total++; if (o_lo !== 32'hFFFF_FFFF) $display("FAIL div0_lo: got %h want ffffffff", o_lo); else n_pass++;
    n_total++; if (o_hi !== 32'd5) $display("FAIL div0_hi: got %h want 5", o_hi); else n_pass++;
  endtask

  // MFHI arrives in cycle 5 of a MULT (prior HI=5) and is held until the stall releases
  task automatic test_hilo_stall();
    int err = 0;
    int seen34 = 0;
    launch(OP_MULT, 32'h0001_0000, 32'h0003_0000);
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c == 1) i_start = 1'b0;
      if (c == 5) i_hilo_read = 1'b1;
      #1;
      if (c < 5 && o_stall !== 1'b0) err++;
      if (c >= 5 && c <= 33 && o_stall !== 1'b1) err++;
      if (c == 33) begin
        n_total++; if (o_hi !== 32'd5) $display("FAIL hi_old_during_fix: got %h want 5", o_hi); else n_pass++;
      end
      if (c == 34) begin
        seen34 = 1;
        n_total++; if (o_stall !== 1'b0) $display("FAIL stall_release: got %b want 0", o_stall); else n_pass++;
        n_total++; if (o_hi !== 32'd3) $display("FAIL mfhi_new_value: got %h want 3", o_hi); else n_pass++;
        n_total++; if (o_done !== 1'b1) $display("FAIL mfhi_done: got %b want 1", o_done); else n_pass++;
        break;
      end
    end
    i_hilo_read = 1'b0;
    n_total++; if (err != 0 || seen34 == 0) $display("FAIL stall_window: got %0d bad cycles want 0", err); else n_pass++;
  endtask

  // A second MULTU is held in EX from cycle 1 and must launch in cycle 34
  task automatic test_back_to_back();
    int err = 0;
    int lat2 = -1;
    launch(OP_MULTU, 32'd2, 32'd3);
    for (int c = 1; c <= 100; c++) begin
      tick();
      if (c == 1) launch(OP_MULTU, 32'd7, 32'd5);
      if (c == 35) i_start = 1'b0;
      #1;
      if (c <= 33 && o_stall !== 1'b1) err++;
      if (c == 34) begin
        n_total++; if (o_stall !== 1'b0) $display("FAIL b2b_stall_release: got %b want 0", o_stall); else n_pass++;
        n_total++; if (o_lo !== 32'd6) $display("FAIL b2b_first_lo: got %h want 6", o_lo); else n_pass++;
      end
      if (c == 35) begin
        n_total++; if (o_busy !== 1'b1) $display("FAIL b2b_second_launch: got %b want 1", o_busy); else n_pass++;
      end
      if (c > 34 && o_done) begin
        lat2 = c;
        break;
      end
    end
    n_total++; if (err != 0) $display("FAIL b2b_stall_window: got %0d bad cycles want 0", err); else n_pass++;
    n_total++; if (lat2 != 68) $display("FAIL b2b_second_latency: got %0d want 68", lat2); else n_pass++;
    n_total++; if (o_lo !== 32'd35) $display("FAIL b2b_second_lo: got %h want 23", o_lo); else n_pass++;
    n_total++; if (o_hi !== 32'd0) $display("FAIL b2b_second_hi: got %h want 0", o_hi); else n_pass++;
  endtask

  // Prior state: HI=0, LO=35
  task automatic test_flush_reset();
    int done_seen = 0;
    launch(OP_DIVU, 32'd100, 32'd7);
    for (int c = 1; c <= 50; c++) begin
      tick();
      if (c == 1) i_start = 1'b0;
      if (c == 10) i_flush = 1'b1;
      if (c == 11) i_flush = 1'b0;
      #1;
      if (c == 11) begin
        n_total++; if (o_busy !== 1'b0) $display("FAIL flush_calc_idle: got %b want 0", o_busy); else n_pass++;
      end
      if (o_done) done_seen = 1;
    end
    n_total++; if (done_seen != 0) $display("FAIL flush_calc_no_done: got %0d want 0", done_seen); else n_pass++;
    n_total++; if (o_lo !== 32'd35) $display("FAIL flush_calc_lo: got %h want 23", o_lo); else n_pass++;
    n_total++; if (o_hi !== 32'd0) $display("FAIL flush_calc_hi: got %h want 0", o_hi); else n_pass++;

    launch(OP_MULTU, 32'd9, 32'd9);
    i_flush = 1'b1;
    tick();
    i_start = 1'b0; i_flush = 1'b0;
    #1;
    n_total++; if (o_busy !== 1'b0) $display("FAIL flush_idle_blocks_start: got %b want 0", o_busy); else n_pass++;

    done_seen = 0;
    launch(OP_MULTU, 32'd9, 32'd9);
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c == 1) i_start = 1'b0;
      if (c == 33) i_flush = 1'b1;
      if (c == 34) i_flush = 1'b0;
      #1;
      if (c == 34) begin
        n_total++; if (o_busy !== 1'b0) $display("FAIL flush_fix_idle: got %b want 0", o_busy); else n_pass++;
      end
      if (o_done) done_seen = 1;
    end
    n_total++; if (done_seen != 0) $display("FAIL flush_fix_no_done: got %0d want 0", done_seen); else n_pass++;
    n_total++; if (o_lo !== 32'd35) $display("FAIL flush_fix_lo: got %h want 23", o_lo); else n_pass++;

    launch(OP_MULTU, 32'd9, 32'd9);
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 1) i_start = 1'b0;
    end
    i_hilo_read = 1'b1;
    #2;
    n_total++; if (o_stall !== 1'b1) $display("FAIL pre_reset_stall: got %b want 1", o_stall); else n_pass++;
    reset = 1'b1;
    #1;
    n_total++; if (o_busy !== 1'b0) $display("FAIL async_reset_busy: got %b want 0", o_busy); else n_pass++;
    n_total++; if (o_stall !== 1'b0) $display("FAIL async_reset_stall: got %b want 0", o_stall); else n_pass++;
    n_total++; if (o_lo !== 32'd0) $display("FAIL async_reset_lo: got %h want 0", o_lo); else n_pass++;
    n_total++; if (o_hi !== 32'd0) $display("FAIL async_reset_hi: got %h want 0", o_hi); else n_pass++;
    n_total++; if (o_done !== 1'b0) $display("FAIL async_reset_done: got %b want 0", o_done); else n_pass++;
    i_hilo_read = 1'b0;
    tick();
    reset = 1'b0;
    tick(); #1;
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_signed();
    test_div_edges();
    test_hilo_stall();
    test_back_to_back();
    test_flush_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
